mq_pe_ctx: RTL and testbench
============================

MQ_PE_CTX -- requirements
Module: mq_pe_ctx

Interface
REQ-001 Parameter NUM_CTX, default 19, number of coding contexts (legal 2..64).
REQ-002 Parameter CX_W, default $clog2(NUM_CTX), context-label width.
REQ-003 clk  in  1  single clock, all state on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 ctx_clear  in  1  pulse; re-initialises all context states.
REQ-006 in_valid/in_ready  in/out  1/1  symbol handshake.
REQ-007 in_d  in  1  decision bit; in_cx  in  CX_W  context label.
REQ-008 out_valid/out_ready  out/in  1/1  result handshake.
REQ-009 out_qe  out  16  Qe value; out_lz  out  4  LZ0 shift count.
REQ-010 out_mps_coding  out  1  1 = MPS path, 0 = LPS path; out_cx  out  CX_W  echo of context.
REQ-011 stat_mps_cnt, stat_lps_cnt  out  32/32  symbol counters (see Configuration).

Function
REQ-012 Per-context state SHALL be {idx[5:0], mps}; the 47-entry Qe table SHALL supply {qe, nmps, nlps, lz, sw} per idx, sw=1 only for idx 0, 6, 14.
REQ-013 Init values: ctx 0 idx 4, ctx 17 idx 3, ctx 18 idx 46 (when NUM_CTX>18), others idx 0; mps 0 for all.
REQ-014 FSM states INIT, RUN; INIT writes one context per cycle, ascending from 0, NUM_CTX cycles, then RUN.
REQ-015 in_ready SHALL be 0 in INIT; in RUN in_ready = !s1_valid || s1 advancing.
REQ-016 Stage S1 loads {cx, d, idx, mps} on in_valid&&in_ready; idx/mps read from the table in the accept cycle.
REQ-017 S1 advances when out register empty or out_ready=1; on advance: mps_coding = ~(d^mps); new idx = mps_coding ? nmps : nlps; new mps = mps ^ (sw & ~mps_coding); write-back to cx; load output register.
REQ-018 Latency: accepted at cycle N, out_valid=1 at N+2 with no backpressure; throughput one symbol/cycle.
REQ-019 Bypass: if accept-cycle in_cx equals the cx being written back in the same cycle, S1 SHALL capture the write data, not the stale table entry.
REQ-020 Output register SHALL hold all out_* stable while out_valid && !out_ready.
REQ-021 idx 46 SHALL map to itself on both paths (uniform context never adapts).
REQ-022 ctx_clear in RUN: in-flight S1 and output contents discarded (out_valid=0 next cycle), FSM to INIT; ctx_clear in INIT restarts sweep at ctx 0.
REQ-023 in_cx >= NUM_CTX: symbol accepted, result undefined, no other context modified.

Reset
REQ-024 rst SHALL clear s1_valid, out_valid, out_qe, out_lz, out_mps_coding, out_cx and stat counters to 0 and enter INIT at ctx 0.
REQ-025 rst SHALL take precedence over ctx_clear and handshakes in the same cycle.

Configuration
REQ-026 Macro MQ_PE_STATS_EN defined: stat_mps_cnt/stat_lps_cnt increment on each S1 advance per path, saturate at 0xFFFFFFFF, clear on rst and ctx_clear.
REQ-027 Macro undefined: stat ports present and tied to 0, no counter flops.

Structure
REQ-028 Package mq_pkg SHALL hold the 47-entry Qe table constant, QE_W=16, IDX_W=6, LZ_W=4, and init-state constants.
REQ-029 One sub-module mq_qe_rom: combinational idx -> {qe, nmps, nlps, lz, sw}.
REQ-030 Context state SHALL be flops (NUM_CTX x 7 bits), no RAM macro.

Verification
REQ-031 rst, hold in_valid=1 -> in_ready=0 for 19 cycles, then 1; stat counters 0.
REQ-032 ctx 0, d=0 -> out_qe 0x0521, out_lz 5, out_mps_coding 1 at N+2; ctx 0 idx becomes 5.
REQ-033 ctx 1 d=1 then ctx 1 d=1 back-to-back -> first qe 0x5601 mps_coding 0 (mps switches to 1, idx 1); second qe 0x3401 mps_coding 1 (bypass).
REQ-034 ctx 18 any d, 5 symbols -> out_qe 0x5601 every time, idx stays 46.
REQ-035 out_ready=0 for 4 cycles with stream -> out_* stable, in_ready drops after S1 fills, no symbol lost or duplicated.
REQ-036 ctx_clear after updating ctx 1 -> out_valid 0 next cycle, 19-cycle INIT, then ctx 1 d=0 yields qe 0x5601 mps_coding 1.

Source files
------------

// File: rtl/mq_pkg.sv
// Shared definitions for the MQ probability-estimation context block:
// the 47-state Qe table, field widths and per-context initial states.
package mq_pkg;

  localparam int QE_W   = 16;
  localparam int IDX_W  = 6;
  localparam int LZ_W   = 4;
  localparam int NUM_QE = 47;

  localparam logic [IDX_W-1:0] INIT_IDX_CX0  = 6'd4;
  localparam logic [IDX_W-1:0] INIT_IDX_CX17 = 6'd3;
  localparam logic [IDX_W-1:0] INIT_IDX_CX18 = 6'd46;
  localparam logic [IDX_W-1:0] INIT_IDX_DEF  = 6'd0;
  localparam logic             INIT_MPS      = 1'b0;

  typedef struct packed {
    logic [QE_W-1:0]  qe;
    logic [IDX_W-1:0] nmps;
    logic [IDX_W-1:0] nlps;
    logic             sw;
  } qe_ent_t;

  localparam qe_ent_t QE_TAB [NUM_QE] = '{
    '{16'h5601, 6'd1,  6'd1,  1'b1}, '{16'h3401, 6'd2,  6'd6,  1'b0},
    '{16'h1801, 6'd3,  6'd9,  1'b0}, '{16'h0AC1, 6'd4,  6'd12, 1'b0},
    '{16'h0521, 6'd5,  6'd29, 1'b0}, '{16'h0221, 6'd38, 6'd33, 1'b0},
    '{16'h5601, 6'd7,  6'd6,  1'b1}, '{16'h5401, 6'd8,  6'd14, 1'b0},
    '{16'h4801, 6'd9,  6'd14, 1'b0}, '{16'h3801, 6'd10, 6'd14, 1'b0},
    '{16'h3001, 6'd11, 6'd17, 1'b0}, '{16'h2401, 6'd12, 6'd18, 1'b0},
    '{16'h1C01, 6'd13, 6'd20, 1'b0}, '{16'h1601, 6'd29, 6'd21, 1'b0},
    '{16'h5601, 6'd15, 6'd14, 1'b1}, '{16'h5401, 6'd16, 6'd14, 1'b0},
    '{16'h5101, 6'd17, 6'd15, 1'b0}, '{16'h4801, 6'd18, 6'd16, 1'b0},
    '{16'h3801, 6'd19, 6'd17, 1'b0}, '{16'h3401, 6'd20, 6'd18, 1'b0},
    '{16'h3001, 6'd21, 6'd19, 1'b0}, '{16'h2801, 6'd22, 6'd19, 1'b0},
    '{16'h2401, 6'd23, 6'd20, 1'b0}, '{16'h2201, 6'd24, 6'd21, 1'b0},
    '{16'h1C01, 6'd25, 6'd22, 1'b0}, '{16'h1801, 6'd26, 6'd23, 1'b0},
    '{16'h1601, 6'd27, 6'd24, 1'b0}, '{16'h1401, 6'd28, 6'd25, 1'b0},
    '{16'h1201, 6'd29, 6'd26, 1'b0}, '{16'h1101, 6'd30, 6'd27, 1'b0},
    '{16'h0AC1, 6'd31, 6'd28, 1'b0}, '{16'h09C1, 6'd32, 6'd29, 1'b0},
    '{16'h08A1, 6'd33, 6'd30, 1'b0}, '{16'h0521, 6'd34, 6'd31, 1'b0},
    '{16'h0441, 6'd35, 6'd32, 1'b0}, '{16'h02A1, 6'd36, 6'd33, 1'b0},
    '{16'h0221, 6'd37, 6'd34, 1'b0}, '{16'h0141, 6'd38, 6'd35, 1'b0},
    '{16'h0111, 6'd39, 6'd36, 1'b0}, '{16'h0085, 6'd40, 6'd37, 1'b0},
    '{16'h0049, 6'd41, 6'd38, 1'b0}, '{16'h0025, 6'd42, 6'd39, 1'b0},
    '{16'h0015, 6'd43, 6'd40, 1'b0}, '{16'h0009, 6'd44, 6'd41, 1'b0},
    '{16'h0005, 6'd45, 6'd42, 1'b0}, '{16'h0001, 6'd45, 6'd43, 1'b0},
    '{16'h5601, 6'd46, 6'd46, 1'b0}
  };

  function automatic logic [IDX_W-1:0] init_idx(input int cx);
    case (cx)
      0:       return INIT_IDX_CX0;
      17:      return INIT_IDX_CX17;
      18:      return INIT_IDX_CX18;
      default: return INIT_IDX_DEF;
    endcase
  endfunction

  // Renormalisation shift count: leading zeros of Qe (Qe is never zero).
  function automatic logic [LZ_W-1:0] count_lz(input logic [QE_W-1:0] qe);
    logic [LZ_W-1:0] n;
    logic            hit;
    n   = '0;
    hit = 1'b0;
    for (int i = QE_W-1; i >= 0; i--) begin
      if (!hit) begin
        if (qe[i]) hit = 1'b1;
        else       n   = n + LZ_W'(1);
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/mq_qe_rom.sv
// Combinational Qe table lookup: idx -> {qe, nmps, nlps, lz, sw}.
// Indices past the table end alias the final (uniform) entry.
module mq_qe_rom
  import mq_pkg::*;
(
  input  logic [IDX_W-1:0] idx,
  output logic [QE_W-1:0]  qe,
  output logic [IDX_W-1:0] nmps,
  output logic [IDX_W-1:0] nlps,
  output logic [LZ_W-1:0]  lz,
  output logic             sw
);

  qe_ent_t ent;

  always_comb begin
    ent = QE_TAB[NUM_QE-1];
    if (idx < IDX_W'(NUM_QE)) ent = QE_TAB[idx];
  end

  assign qe   = ent.qe;
  assign nmps = ent.nmps;
  assign nlps = ent.nlps;
  assign sw   = ent.sw;
  assign lz   = count_lz(ent.qe);

endmodule

// File: rtl/mq_pe_ctx.sv
// MQ probability-estimation context store: 2-cycle pipeline, 1 symbol/cycle, stalls on out_ready.
// Optional symbol statistics are built when MQ_PE_STATS_EN is defined.
module mq_pe_ctx
  import mq_pkg::*;
#(
  parameter int NUM_CTX = 19,
  parameter int CX_W    = $clog2(NUM_CTX)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ctx_clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_d,
  input  logic [CX_W-1:0]  in_cx,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [QE_W-1:0]  out_qe,
  output logic [LZ_W-1:0]  out_lz,
  output logic             out_mps_coding,
  output logic [CX_W-1:0]  out_cx,
  output logic [31:0]      stat_mps_cnt,
  output logic [31:0]      stat_lps_cnt
);

  typedef enum logic {INIT, RUN} state_t;

  state_t           state, state_nx;
  logic [CX_W-1:0]  init_cnt;
  logic             init_last;

  logic [IDX_W-1:0] ctx_idx [NUM_CTX];
  logic             ctx_mps [NUM_CTX];

  logic             s1_valid, s1_d, s1_mps;
  logic [CX_W-1:0]  s1_cx;
  logic [IDX_W-1:0] s1_idx;

  logic [QE_W-1:0]  rom_qe;
  logic [IDX_W-1:0] rom_nmps, rom_nlps;
  logic [LZ_W-1:0]  rom_lz;
  logic             rom_sw;

  logic             adv, accept, byp, mps_coding, wb_mps, rd_mps;
  logic [IDX_W-1:0] wb_idx, rd_idx;

  assign init_last = (init_cnt == CX_W'(NUM_CTX-1));

  always_ff @(posedge clk) begin
    if (rst) state <= INIT;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    case (state)
      INIT: begin
        if (!ctx_clear && init_last) state_nx = RUN;
      end
      RUN: begin
        in_ready = !s1_valid || adv;
        if (ctx_clear) state_nx = INIT;
      end
      default: state_nx = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || ctx_clear)                init_cnt <= '0;
    else if (state == INIT && !init_last) init_cnt <= init_cnt + 1'b1;
  end

  mq_qe_rom u_rom (
    .idx  (s1_idx),
    .qe   (rom_qe),
    .nmps (rom_nmps),
    .nlps (rom_nlps),
    .lz   (rom_lz),
    .sw   (rom_sw)
  );

  assign accept     = in_valid && in_ready;
  assign adv        = s1_valid && (!out_valid || out_ready);
  assign mps_coding = ~(s1_d ^ s1_mps);
  assign wb_idx     = mps_coding ? rom_nmps : rom_nlps;
  assign wb_mps     = s1_mps ^ (rom_sw & ~mps_coding);
  // Same-context follow-on symbol must see the update being written this cycle.
  assign byp        = adv && (in_cx == s1_cx);

  always_comb begin
    rd_idx = '0;
    rd_mps = 1'b0;
    for (int c = 0; c < NUM_CTX; c++) begin
      if (in_cx == CX_W'(c)) begin
        rd_idx = ctx_idx[c];
        rd_mps = ctx_mps[c];
      end
    end
  end

  // Out-of-range labels match no entry, so they never disturb stored state.
  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CTX; c++) begin
      if (state == INIT) begin
        if (init_cnt == CX_W'(c)) begin
          ctx_idx[c] <= init_idx(c);
          ctx_mps[c] <= INIT_MPS;
        end
      end else if (adv && s1_cx == CX_W'(c)) begin
        ctx_idx[c] <= wb_idx;
        ctx_mps[c] <= wb_mps;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || ctx_clear) s1_valid <= 1'b0;
    else if (accept)      s1_valid <= 1'b1;
    else if (adv)         s1_valid <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      s1_cx  <= in_cx;
      s1_d   <= in_d;
      s1_idx <= byp ? wb_idx : rd_idx;
      s1_mps <= byp ? wb_mps : rd_mps;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid      <= 1'b0;
      out_qe         <= '0;
      out_lz         <= '0;
      out_mps_coding <= 1'b0;
      out_cx         <= '0;
    end else if (ctx_clear) begin
      out_valid <= 1'b0;
    end else if (adv) begin
      out_valid      <= 1'b1;
      out_qe         <= rom_qe;
      out_lz         <= rom_lz;
      out_mps_coding <= mps_coding;
      out_cx         <= s1_cx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef MQ_PE_STATS_EN
  logic [31:0] mps_cnt, lps_cnt;

  always_ff @(posedge clk) begin
    if (rst || ctx_clear) begin
      mps_cnt <= '0;
      lps_cnt <= '0;
    end else if (adv) begin
      if (mps_coding && mps_cnt != '1)  mps_cnt <= mps_cnt + 1'b1;
      if (!mps_coding && lps_cnt != '1) lps_cnt <= lps_cnt + 1'b1;
    end
  end

  assign stat_mps_cnt = mps_cnt;
  assign stat_lps_cnt = lps_cnt;
`else
  assign stat_mps_cnt = '0;
  assign stat_lps_cnt = '0;
`endif

endmodule

// File: tb/tb_mq_pe_ctx.sv
// Bench for mq_pe_ctx: directed steps plus random traffic against a
// sequential context-adaptation model with an in-order result queue.
module tb_mq_pe_ctx;

  localparam int NCTX = 19;
  localparam int CXW  = $clog2(NCTX);

  logic            clk = 1'b0;
  logic            rst, ctx_clear, in_valid, in_ready, in_d;
  logic [CXW-1:0]  in_cx;
  logic            out_valid, out_ready, out_mps_coding;
  logic [15:0]     out_qe;
  logic [3:0]      out_lz;
  logic [CXW-1:0]  out_cx;
  logic [31:0]     stat_mps_cnt, stat_lps_cnt;

  mq_pe_ctx #(.NUM_CTX(NCTX)) dut (
    .clk            (clk),
    .rst            (rst),
    .ctx_clear      (ctx_clear),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_d           (in_d),
    .in_cx          (in_cx),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_qe         (out_qe),
    .out_lz         (out_lz),
    .out_mps_coding (out_mps_coding),
    .out_cx         (out_cx),
    .stat_mps_cnt   (stat_mps_cnt),
    .stat_lps_cnt   (stat_lps_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  int tqe [47] = '{
    'h5601, 'h3401, 'h1801, 'h0AC1, 'h0521, 'h0221, 'h5601, 'h5401, 'h4801, 'h3801,
    'h3001, 'h2401, 'h1C01, 'h1601, 'h5601, 'h5401, 'h5101, 'h4801, 'h3801, 'h3401,
    'h3001, 'h2801, 'h2401, 'h2201, 'h1C01, 'h1801, 'h1601, 'h1401, 'h1201, 'h1101,
    'h0AC1, 'h09C1, 'h08A1, 'h0521, 'h0441, 'h02A1, 'h0221, 'h0141, 'h0111, 'h0085,
    'h0049, 'h0025, 'h0015, 'h0009, 'h0005, 'h0001, 'h5601};
  int tnmps [47] = '{
    1, 2, 3, 4, 5, 38, 7, 8, 9, 10, 11, 12, 13, 29, 15, 16, 17, 18, 19, 20,
    21, 22, 23, 24, 25, 26, 27, 28, 29, 30, 31, 32, 33, 34, 35, 36, 37, 38, 39, 40,
    41, 42, 43, 44, 45, 45, 46};
  int tnlps [47] = '{
    1, 6, 9, 12, 29, 33, 6, 14, 14, 14, 17, 18, 20, 21, 14, 14, 15, 16, 17, 18,
    19, 19, 20, 21, 22, 23, 24, 25, 26, 27, 28, 29, 30, 31, 32, 33, 34, 35, 36, 37,
    38, 39, 40, 41, 42, 43, 46};

  function automatic int lz_of(input int q);
    for (int b = 15; b >= 0; b--) if (q[b]) return 15 - b;
    return 16;
  endfunction

  function automatic bit sw_of(input int i);
    return (i == 0 || i == 6 || i == 14);
  endfunction

  typedef struct { int qe; int lz; int mc; int cx; } res_t;

  res_t expq [$];
  res_t outlog [$];
  int   m_idx [NCTX];
  int   m_mps [NCTX];
  int   m_nmps, m_nlps;

  task automatic model_reset();
    for (int c = 0; c < NCTX; c++) begin
      m_idx[c] = (c == 0) ? 4 : (c == 17) ? 3 : (c == 18) ? 46 : 0;
      m_mps[c] = 0;
    end
    expq.delete();
    m_nmps = 0;
    m_nlps = 0;
  endtask

  task automatic model_accept(input int cx, input int d);
    res_t e;
    int   i;
    i    = m_idx[cx];
    e.qe = tqe[i];
    e.lz = lz_of(tqe[i]);
    e.mc = (d == m_mps[cx]) ? 1 : 0;
    e.cx = cx;
    expq.push_back(e);
    if (e.mc == 1) begin
      m_idx[cx] = tnmps[i];
      m_nmps++;
    end else begin
      m_idx[cx] = tnlps[i];
      m_nlps++;
      if (sw_of(i)) m_mps[cx] = 1 - m_mps[cx];
    end
  endtask

  // Transfers are judged at the negedge preceding the edge that performs them.
  always @(negedge clk) begin : sb
    res_t e, o;
    if (rst || ctx_clear) begin
      model_reset();
    end else begin
      if (out_valid && out_ready) begin
        o.qe = int'(out_qe);
        o.lz = int'(out_lz);
        o.mc = int'(out_mps_coding);
        o.cx = int'(out_cx);
        outlog.push_back(o);
        if (expq.size() == 0) begin
          chk("unexpected_output", 32'(out_valid), 32'd0);
        end else begin
          e = expq.pop_front();
          chk("sb_qe", 32'(out_qe), e.qe);
          chk("sb_lz", 32'(out_lz), e.lz);
          chk("sb_mps_coding", 32'(out_mps_coding), e.mc);
          chk("sb_cx", 32'(out_cx), e.cx);
        end
      end
      if (in_valid && in_ready) model_accept(int'(in_cx), int'(in_d));
    end
  end

  task automatic send(input int cx, input int d);
    bit done;
    done     = 1'b0;
    in_valid = 1'b1;
    in_cx    = CXW'(cx);
    in_d     = d[0];
    for (int t = 0; t < 100 && !done; t++) begin
      @(negedge clk);
      if (in_ready) done = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!done) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic get_out(output res_t o);
    int t;
    t = 0;
    while (outlog.size() == 0 && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    if (outlog.size() == 0) begin
      chk("output_timeout", 32'd0, 32'd1);
      o = '{-1, -1, -1, -1};
    end else begin
      o = outlog.pop_front();
    end
  endtask

  task automatic drain();
    int t;
    t         = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while ((expq.size() != 0 || out_valid) && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    chk("drain_queue_empty", expq.size(), 32'd0);
    chk("drain_out_valid", 32'(out_valid), 32'd0);
  endtask

  task automatic check_stats(input string tag);
`ifdef MQ_PE_STATS_EN
    chk({tag, "_stat_mps"}, stat_mps_cnt, m_nmps);
    chk({tag, "_stat_lps"}, stat_lps_cnt, m_nlps);
`else
    chk({tag, "_stat_mps"}, stat_mps_cnt, 32'd0);
    chk({tag, "_stat_lps"}, stat_lps_cnt, 32'd0);
`endif
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired before the bench completed");
    $fatal(1, "watchdog");
  end

  initial begin
    res_t o;
    bit   stall_prev, saw_drop, acc;
    logic [15:0] h_qe;
    logic [3:0]  h_lz;
    logic        h_mc;
    logic [CXW-1:0] h_cx;
    int   t;

    rst = 1'b1; ctx_clear = 1'b0; in_valid = 1'b0; in_d = 1'b0;
    in_cx = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_qe", 32'(out_qe), 32'd0);
    chk("rst_out_cx", 32'(out_cx), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_stat_mps", stat_mps_cnt, 32'd0);
    chk("rst_stat_lps", stat_lps_cnt, 32'd0);

    // Hold a ctx-0 MPS symbol through the init sweep.
    rst = 1'b0; in_valid = 1'b1; in_cx = '0; in_d = 1'b0;
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      chk("init_in_ready_low", 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    chk("init_in_ready_high", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("lat_n1_out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("lat_n2_out_valid", 32'(out_valid), 32'd1);
    chk("ctx0_qe", 32'(out_qe), 32'h0521);
    chk("ctx0_lz", 32'(out_lz), 32'd5);
    chk("ctx0_mps_coding", 32'(out_mps_coding), 32'd1);
    @(posedge clk); #1;
    outlog.delete();

    send(0, 0);
    get_out(o);
    chk("ctx0_idx5_qe", o.qe, 32'h0221);
    chk("ctx0_idx5_lz", o.lz, 32'd6);

    send(1, 1);
    send(1, 1);
    get_out(o);
    chk("ctx1_first_qe", o.qe, 32'h5601);
    chk("ctx1_first_mc", o.mc, 32'd0);
    get_out(o);
    chk("ctx1_bypass_qe", o.qe, 32'h3401);
    chk("ctx1_bypass_mc", o.mc, 32'd1);

    for (int i = 0; i < 5; i++) send(18, int'($urandom_range(0, 1)));
    for (int i = 0; i < 5; i++) begin
      get_out(o);
      chk("ctx18_uniform_qe", o.qe, 32'h5601);
      chk("ctx18_uniform_cx", o.cx, 32'd18);
    end
    drain();
    check_stats("directed");

    // Continuous stream with a 4-cycle output stall.
    stall_prev = 1'b0; saw_drop = 1'b0;
    h_qe = '0; h_lz = '0; h_mc = 1'b0; h_cx = '0;
    in_valid = 1'b1;
    in_cx = CXW'($urandom_range(0, NCTX-1));
    in_d = 1'($urandom_range(0, 1));
    for (int cyc = 0; cyc < 30; cyc++) begin
      out_ready = (cyc >= 10 && cyc < 14) ? 1'b0 : 1'b1;
      @(negedge clk);
      if (stall_prev) begin
        chk("stall_out_valid", 32'(out_valid), 32'd1);
        chk("stall_out_qe", 32'(out_qe), 32'(h_qe));
        chk("stall_out_lz", 32'(out_lz), 32'(h_lz));
        chk("stall_out_mc", 32'(out_mps_coding), 32'(h_mc));
        chk("stall_out_cx", 32'(out_cx), 32'(h_cx));
      end
      stall_prev = out_valid && !out_ready;
      h_qe = out_qe; h_lz = out_lz; h_mc = out_mps_coding; h_cx = out_cx;
      if (!out_ready && !in_ready) saw_drop = 1'b1;
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) begin
        in_cx = CXW'($urandom_range(0, NCTX-1));
        in_d  = 1'($urandom_range(0, 1));
      end
    end
    chk("stall_in_ready_drop", 32'(saw_drop), 32'd1);

    for (int cyc = 0; cyc < 300; cyc++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      in_cx     = CXW'($urandom_range(0, NCTX-1));
      in_d      = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 9) < 7);
      @(posedge clk); #1;
    end
    drain();
    check_stats("random");
    outlog.delete();

    // Leave a result pending, then clear.
    out_ready = 1'b0;
    send(1, 0);
    t = 0;
    while (!out_valid && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    chk("pre_clear_out_valid", 32'(out_valid), 32'd1);
    ctx_clear = 1'b1;
    @(posedge clk); #1;
    ctx_clear = 1'b0;
    chk("clear_out_valid", 32'(out_valid), 32'd0);
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      chk("clear_in_ready_low", 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    chk("clear_in_ready_high", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    outlog.delete();
    send(1, 0);
    get_out(o);
    chk("after_clear_qe", o.qe, 32'h5601);
    chk("after_clear_mc", o.mc, 32'd1);
    drain();
    check_stats("after_clear");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
